// File: rtl/decode_regfile_if.sv
// Bus bundle between the decode/regfile stage and its neighbours.
// Inputs:  instr (instruction word), dst_addr/dst/we (writeback port), hlt (halt).
// Outputs: alu1/alu2 (operands), imm (memory offset), p0_addr/p1_addr/re0/re1/p0/p1 (read ports).
interface decode_regfile_if;
   logic [15:0] instr;
   logic [3:0]  dst_addr;
   logic [15:0] dst;
   logic        we;
   logic        hlt;
   logic [15:0] alu1;
   logic [15:0] alu2;
   logic [15:0] imm;
   logic [3:0]  p0_addr;
   logic [3:0]  p1_addr;
   logic        re0;
   logic        re1;
   logic [15:0] p0;
   logic [15:0] p1;

   modport master (
      output instr, dst_addr, dst, we, hlt,
      input  alu1, alu2, imm, p0_addr, p1_addr, re0, re1, p0, p1
   );

   modport slave (
      input  instr, dst_addr, dst, we, hlt,
      output alu1, alu2, imm, p0_addr, p1_addr, re0, re1, p0, p1
   );
endinterface

// File: rtl/decode_regfile.sv
// Instruction decode merged with the 16x16 register file.
// clk   : system clock, all state changes on the rising edge
// rst_n : synchronous active-low reset, clears every register
// bus   : decode_regfile_if.slave -- instruction and writeback port in,
//         ALU operands, immediate and read-port observability out
// Register reads and decode are combinational; only the register array is clocked.
module decode_regfile (
   input  logic            clk,
   input  logic            rst_n,
   decode_regfile_if.slave bus
);
   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_NAND = 4'h2;
   localparam logic [3:0] OP_XOR  = 4'h3;
   localparam logic [3:0] OP_INC  = 4'h4;
   localparam logic [3:0] OP_SRA  = 4'h5;
   localparam logic [3:0] OP_SRL  = 4'h6;
   localparam logic [3:0] OP_SLL  = 4'h7;
   localparam logic [3:0] OP_SW   = 4'h8;
   localparam logic [3:0] OP_LW   = 4'h9;
   localparam logic [3:0] OP_LHB  = 4'hA;
   localparam logic [3:0] OP_LLB  = 4'hB;
   localparam logic [3:0] OP_CALL = 4'hD;
   localparam logic [3:0] OP_RET  = 4'hE;

   localparam logic [3:0] REG_DS  = 4'd14;
   localparam logic [3:0] REG_SP  = 4'd15;

   // Register storage; name kept as mem for hierarchical preloading.
   logic [15:0] mem [0:15];

   logic [3:0]  w_op;
   logic [3:0]  w_rd;
   logic [3:0]  w_rs;
   logic [3:0]  w_rt;
   logic [3:0]  w_p0_addr;
   logic [3:0]  w_p1_addr;
   logic        w_re0;
   logic        w_re1;
   logic [15:0] w_p0;
   logic [15:0] w_p1;
   logic [15:0] w_imm;
   logic [15:0] w_alu1;
   logic [15:0] w_alu2;

   assign w_op = bus.instr[15:12];
   assign w_rd = bus.instr[11:8];
   assign w_rs = bus.instr[7:4];
   assign w_rt = bus.instr[3:0];

   // Reset wins over writeback; register 0 is never written.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 16; i++) begin
            mem[i] <= '0;
         end
      end else if (bus.we && !bus.hlt && (bus.dst_addr != 4'd0)) begin
         mem[bus.dst_addr] <= bus.dst;
      end
   end

   // Read-port address/enable selection.
   always_comb begin
      w_p0_addr = '0;
      w_p1_addr = '0;
      w_re0     = 1'b0;
      w_re1     = 1'b0;
      case (w_op)
         OP_ADD, OP_SUB, OP_NAND, OP_XOR: begin
            w_p0_addr = w_rs;
            w_p1_addr = w_rt;
            w_re0     = 1'b1;
            w_re1     = 1'b1;
         end
         OP_INC, OP_SRA, OP_SRL, OP_SLL: begin
            w_p0_addr = w_rs;
            w_re0     = 1'b1;
         end
         OP_SW: begin
            w_p0_addr = w_rd;
            w_p1_addr = REG_DS;
            w_re0     = 1'b1;
            w_re1     = 1'b1;
         end
         OP_LW: begin
            w_p1_addr = REG_DS;
            w_re1     = 1'b1;
         end
         OP_LHB, OP_LLB: begin
            w_p0_addr = w_rd;
            w_re0     = 1'b1;
         end
         OP_CALL, OP_RET: begin
            w_p0_addr = REG_SP;
            w_re0     = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Register 0 is forced to read zero regardless of storage contents.
   assign w_p0 = (w_re0 && (w_p0_addr != 4'd0)) ? mem[w_p0_addr] : '0;
   assign w_p1 = (w_re1 && (w_p1_addr != 4'd0)) ? mem[w_p1_addr] : '0;

   assign w_imm = ((w_op == OP_SW) || (w_op == OP_LW)) ? {8'h00, bus.instr[7:0]} : '0;

   // Operand formation; each arm only looks at the instruction bits its opcode defines,
   // so unknowns on don't-care bits cannot reach the operands.
   always_comb begin
      w_alu1 = '0;
      w_alu2 = '0;
      case (w_op)
         OP_ADD, OP_SUB, OP_NAND, OP_XOR, OP_SW: begin
            w_alu1 = w_p0;
            w_alu2 = w_p1;
         end
         OP_INC: begin
            w_alu1 = w_p0;
            w_alu2 = {{12{bus.instr[3]}}, bus.instr[3:0]};
         end
         OP_SRA, OP_SRL, OP_SLL: begin
            w_alu1 = w_p0;
            w_alu2 = {12'h000, bus.instr[3:0]};
         end
         OP_LW: begin
            w_alu1 = w_imm;
            w_alu2 = w_p1;
         end
         OP_LHB, OP_LLB: begin
            w_alu1 = w_p0;
            w_alu2 = {8'h00, bus.instr[7:0]};
         end
         OP_CALL: begin
            w_alu1 = w_p0;
            w_alu2 = 16'hFFFF;
         end
         OP_RET: begin
            w_alu1 = w_p0;
            w_alu2 = 16'h0001;
         end
         default: begin
         end
      endcase
   end

   assign bus.alu1    = w_alu1;
   assign bus.alu2    = w_alu2;
   assign bus.imm     = w_imm;
   assign bus.p0_addr = w_p0_addr;
   assign bus.p1_addr = w_p1_addr;
   assign bus.re0     = w_re0;
   assign bus.re1     = w_re1;
   assign bus.p0      = w_p0;
   assign bus.p1      = w_p1;
endmodule

// File: tb/tb_decode_regfile.sv
// Self-checking bench for decode_regfile: directed test-plan steps followed by
// randomized writeback/instruction traffic checked against a behavioural model.
module tb_decode_regfile;
   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   logic [15:0] m_mem [16];

   decode_regfile_if bus ();

   decode_regfile dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] rdm(input logic [3:0] a);
      return (a == 4'd0) ? 16'h0000 : m_mem[a];
   endfunction

   // Architectural expectation of every decode output for one instruction.
   task automatic check_instr(input string tag, input logic [15:0] ins);
      logic [3:0]  op, rd, rs, rt, a0, a1;
      logic        r0, r1;
      logic [15:0] e1, e2, ei, ep0, ep1;
      int          sx;
      op = ins[15:12]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
      a0 = 0; a1 = 0; r0 = 0; r1 = 0; ei = 0;
      if (op <= 4'h3) begin a0 = rs; a1 = rt; r0 = 1; r1 = 1; end
      else if (op <= 4'h7) begin a0 = rs; r0 = 1; end
      else if (op == 4'h8) begin a0 = rd; a1 = 14; r0 = 1; r1 = 1; ei = 16'(ins[7:0]); end
      else if (op == 4'h9) begin a1 = 14; r1 = 1; ei = 16'(ins[7:0]); end
      else if (op == 4'hA || op == 4'hB) begin a0 = rd; r0 = 1; end
      else if (op == 4'hD || op == 4'hE) begin a0 = 15; r0 = 1; end
      ep0 = r0 ? rdm(a0) : 16'h0;
      ep1 = r1 ? rdm(a1) : 16'h0;
      e1 = ep0; e2 = ep1;
      case (op)
         4'h4: begin sx = (int'(rt) >= 8) ? int'(rt) - 16 : int'(rt); e2 = sx[15:0]; end
         4'h5, 4'h6, 4'h7: e2 = 16'(rt);
         4'h9: e1 = ei;
         4'hA, 4'hB: e2 = 16'(ins[7:0]);
         4'hD: e2 = 16'hFFFF;
         4'hE: e2 = 16'h0001;
         4'hC, 4'hF: begin e1 = 0; e2 = 0; end
         default: ;
      endcase
      bus.instr = ins;
      #1;
      chk({tag, ".alu1"}, bus.alu1, e1);
      chk({tag, ".alu2"}, bus.alu2, e2);
      chk({tag, ".imm"}, bus.imm, ei);
      chk({tag, ".p0_addr"}, 16'(bus.p0_addr), 16'(a0));
      chk({tag, ".p1_addr"}, 16'(bus.p1_addr), 16'(a1));
      chk({tag, ".re0"}, 16'(bus.re0), 16'(r0));
      chk({tag, ".re1"}, 16'(bus.re1), 16'(r1));
      chk({tag, ".p0"}, bus.p0, ep0);
      chk({tag, ".p1"}, bus.p1, ep1);
   endtask

   // One writeback edge; model applies the architectural write rule.
   task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic w, input logic h);
      @(negedge clk);
      bus.we = w; bus.hlt = h; bus.dst_addr = a; bus.dst = d;
      @(negedge clk);
      bus.we = 1'b0; bus.hlt = 1'b0;
      if (w && !h && a != 4'd0) m_mem[a] = d;
   endtask

   initial begin
      logic [15:0] xi;
      logic [15:0] r;
      errors = 0; checks = 0;
      for (int i = 0; i < 16; i++) m_mem[i] = 16'h0;
      rst_n = 1'b0;
      bus.instr = 16'h0123; bus.we = 1'b0; bus.hlt = 1'b0; bus.dst_addr = 4'd0; bus.dst = 16'h0;
      repeat (2) @(negedge clk);
      check_instr("reset_add", 16'h0123);
      check_instr("reset_ret", 16'hE000);
      rst_n = 1'b1;

      // Directed test plan
      wr(2, 16'hABCD, 1, 0); wr(3, 16'hDEAD, 1, 0); check_instr("add", 16'h0123);
      wr(2, 16'hBEEF, 1, 0); wr(3, 16'hFACE, 1, 0); check_instr("sub", 16'h1123);
      wr(2, 16'hFEE1, 1, 0); wr(3, 16'hC0DE, 1, 0); check_instr("nand", 16'h2123);
      wr(2, 16'hCAFE, 1, 0); wr(3, 16'hD00D, 1, 0); check_instr("xor", 16'h3123);
      wr(2, 16'hBABE, 1, 0); check_instr("inc", 16'h412F);
      check_instr("inc_pos", 16'h4127);
      wr(2, 16'h0001, 1, 0); check_instr("sra", 16'h5128);
      wr(2, 16'h1001, 1, 0); check_instr("srl", 16'h6128);
      wr(2, 16'h1011, 1, 0); check_instr("sll", 16'h7128);
      wr(2, 16'hF00D, 1, 0); wr(14, 16'hB00B, 1, 0); check_instr("sw", 16'h82AD);
      wr(14, 16'hB105, 1, 0); check_instr("lw", 16'h9255);
      wr(2, 16'hBEAF, 1, 0); check_instr("lhb", 16'hA2EB);
      wr(2, 16'hFA11, 1, 0); check_instr("llb", 16'hB21B);
      wr(15, 16'h10CC, 1, 0); check_instr("call", 16'hD012);
      wr(15, 16'h4B1D, 1, 0);
      xi = 16'hExxx;
      bus.instr = xi; #1;
      chk("ret_x.alu1", bus.alu1, 16'h4B1D);
      chk("ret_x.alu2", bus.alu2, 16'h0001);
      chk("ret_x.imm", bus.imm, 16'h0000);
      xi = 16'hCxxx;
      bus.instr = xi; #1;
      chk("b_x.alu1", bus.alu1, 16'h0000);
      chk("b_x.alu2", bus.alu2, 16'h0000);
      check_instr("hlt", 16'hF123);

      // Writeback, halt, register 0, no bypass, reset priority
      wr(5, 16'h1234, 1, 0); check_instr("wb", 16'h0050);
      wr(5, 16'h9999, 1, 1); check_instr("wb_hlt", 16'h0050);
      wr(5, 16'h7777, 0, 0); check_instr("wb_we0", 16'h0050);
      wr(0, 16'hFFFF, 1, 0); check_instr("wb_r0", 16'h0005);
      @(negedge clk);
      bus.we = 1'b1; bus.dst_addr = 4'd5; bus.dst = 16'h5555; bus.instr = 16'h0050;
      #1;
      chk("no_bypass", bus.alu1, 16'h1234);
      @(negedge clk);
      bus.we = 1'b0; m_mem[5] = 16'h5555;
      check_instr("after_write", 16'h0050);
      for (int i = 1; i < 16; i++) wr(4'(i), 16'($urandom), 1, 0);
      @(negedge clk);
      rst_n = 1'b0; bus.we = 1'b1; bus.dst_addr = 4'd3; bus.dst = 16'hAAAA;
      @(negedge clk);
      rst_n = 1'b1; bus.we = 1'b0;
      for (int i = 0; i < 16; i++) m_mem[i] = 16'h0;
      for (int i = 0; i < 16; i++) begin
         bus.instr = {8'h00, 4'(i), 4'(i)}; #1;
         chk("reset_clear.p0", bus.p0, 16'h0000);
      end

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         r = 16'($urandom);
         wr(4'($urandom_range(0, 15)), 16'($urandom), r[0] | r[1], (r[3:2] == 2'b00));
         check_instr("rand", 16'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
